chan_bitstream_reader: RTL and testbench
========================================

# chan_bitstream_reader

SPI flash read engine that fetches the channel-FPGA configuration bitstream and streams it, one bit per clock, to the channel programming state machine. Sits between the on-board SPI configuration flash and the channel programmer: consumes the programmer's `store_flash_command` / `read_bitstream` / `prog_chan_in_progress` controls and returns the serial `bitstream` plus an `end_bitstream` completion flag.

## Interface
- `START_ADDR`, 24'hCE0000, flash byte address of the first channel bitstream byte
- `NUM_BITS`, 32'd21_728_640, bitstream length in bits (legal range 1 .. 2^32-1)
- `clk`  in  1  system clock; flash SCK is `clk` inverted, gated by `spi_sck_en`
- `reset_n`  in  1  asynchronous, active-low reset
- `prog_chan_in_progress`  in  1  level; high while a channel programming sequence is active
- `store_flash_command`  in  1  single-cycle pulse; latch command/address and arm the engine
- `read_bitstream`  in  1  level; high for the whole load phase
- `spi_miso`  in  1  flash data out
- `spi_cs_n`  out  1  flash chip select, active low
- `spi_mosi`  out  1  flash data in
- `spi_sck_en`  out  1  SCK gate enable, high only while `spi_cs_n` is low
- `bitstream`  out  1  serial bitstream bit, MSB of each byte first
- `end_bitstream`  out  1  level; final bit presented / load complete

## Operation
- Reset values: `spi_cs_n`=1, `spi_mosi`=0, `spi_sck_en`=0, `bitstream`=1, `end_bitstream`=0, state IDLE, bit counter 0.
- `bitstream` is held at 1 whenever no captured flash bit is being presented (pad value harmless to configuration logic).
- States:
  - IDLE: on `store_flash_command`=1 latch shift register = {READ_CMD, START_ADDR} -> ARMED. `read_bitstream` alone is ignored.
  - ARMED: on `read_bitstream`=1 -> CMD, drive `spi_cs_n`=0, `spi_sck_en`=1.
  - CMD: shift 8 command bits on `spi_mosi`, MSB first -> ADDR.
  - ADDR: shift 24 address bits, MSB first -> STREAM (or DUMMY, see Configuration).
  - STREAM: each cycle capture `spi_miso` into `bitstream`; 32-bit counter increments per bit; when counter = NUM_BITS-1 -> END.
  - END: `spi_cs_n`=1, `spi_sck_en`=0, `end_bitstream`=1, `bitstream`=1; hold until `read_bitstream`=0 -> IDLE, `end_bitstream`=0.
- Abort: `prog_chan_in_progress`=0 in any state other than IDLE/END -> IDLE next cycle, `spi_cs_n`=1, `end_bitstream` never asserted.
- `store_flash_command` outside IDLE is ignored; `read_bitstream` falling before END -> abort as above.
- READ_CMD = 8'h03.

## Timing
- `spi_mosi` changes on rising `clk`; flash samples on rising SCK (falling `clk`). `spi_miso` sampled on rising `clk`.
- Cycle 0 = first cycle with `spi_cs_n`=0 (one cycle after `read_bitstream` sampled high in ARMED).
- Cycles 0-7 command, 8-31 address, flash drives data bit k in cycle 32+k.
- Bit k appears on `bitstream` during cycle 33+k; latency read_bitstream-high to first data bit = 34 clocks.
- Final bit (k = NUM_BITS-1) and `end_bitstream` rise in the same cycle (33+NUM_BITS-1) so the consumer latches the last bit as it exits its load state; `spi_cs_n` returns high that same cycle.
- Total CS-low time = 32+NUM_BITS cycles.
- Asynchronous reset takes effect immediately; `spi_cs_n` goes high without waiting for a clock.

## Configuration
- `CHAN_FAST_READ_EN` defined: READ_CMD = 8'h0B; DUMMY state inserts 8 SCK cycles after ADDR (MOSI=0, MISO ignored); all data-bit timings shift +8 cycles (first bit on `bitstream` at cycle 41).
- Undefined: READ_CMD = 8'h03, no DUMMY state, timings as above.

## Test plan
- Nominal (NUM_BITS=16, flash model holds 16'hA55A at 0xCE0000): pulse store, raise read -> MOSI shows 0x03 then 0xCE0000; `bitstream` = 1010010101011010 in cycles 33-48; `end_bitstream`=1 at cycle 48, `spi_cs_n`=1 at cycle 48.
- Handshake release: hold read 5 cycles after `end_bitstream` -> flag stays 1; drop read -> flag 0 and state IDLE next cycle; second store/read repeats identically.
- Read without store: `read_bitstream`=1 from IDLE -> `spi_cs_n` stays 1, `bitstream`=1, no `end_bitstream`.
- Abort: drop `prog_chan_in_progress` at cycle 20 (in ADDR) -> `spi_cs_n`=1 next cycle, `end_bitstream` remains 0, IDLE.
- Async reset at cycle 40 (STREAM) -> `spi_cs_n`=1, `bitstream`=1, `end_bitstream`=0 before next clock edge.
- With `CHAN_FAST_READ_EN`: MOSI shows 0x0B, address, 8 zero bits; first data bit on `bitstream` at cycle 41, `end_bitstream` at cycle 56 for NUM_BITS=16.

Source files
------------

// File: rtl/chan_bitstream_reader.sv
// chan_bitstream_reader
//   Fetches the channel-FPGA configuration bitstream from the SPI configuration
//   flash and presents it one bit per clock to the channel programmer.
//   The flash SCK is clk inverted, gated by spi_sck_en. MOSI is launched on
//   rising clk, and MISO is captured on rising clk.
//
// Parameters
//   START_ADDR  flash byte address of the first bitstream byte
//   NUM_BITS    bitstream length in bits (1 .. 2^32-1)
// Build option
//   CHAN_FAST_READ_EN  uses the FAST READ command (0x0B) with 8 dummy clocks
//                      after the address. Undefined: plain READ (0x03).
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   prog_chan_in_progress   level; dropping it aborts an active load
//   store_flash_command     pulse; arms the engine (accepted in IDLE only)
//   read_bitstream          level; starts the load and holds the END handshake
//   spi_miso                flash data out
//   spi_cs_n, spi_mosi      flash chip select (active low), flash data in
//   spi_sck_en              SCK gate; high only while spi_cs_n is low
//   bitstream               serial data, MSB of each byte first; 1 when idle
//   end_bitstream           high from the final data bit until read_bitstream drops
module chan_bitstream_reader #(
  parameter logic [23:0] START_ADDR = 24'hCE0000,
  parameter logic [31:0] NUM_BITS   = 32'd21_728_640
) (
  input  logic clk,
  input  logic reset_n,
  input  logic prog_chan_in_progress,
  input  logic store_flash_command,
  input  logic read_bitstream,
  input  logic spi_miso,
  output logic spi_cs_n,
  output logic spi_mosi,
  output logic spi_sck_en,
  output logic bitstream,
  output logic end_bitstream
);

`ifdef CHAN_FAST_READ_EN
  localparam logic [7:0] READ_CMD = 8'h0B;
`else
  localparam logic [7:0] READ_CMD = 8'h03;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_CMD, S_ADDR, S_DUMMY, S_STREAM, S_END
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] sreg_q, sreg_d;   // {command, address}; MSB is next on MOSI
  logic [31:0] cnt_q, cnt_d;     // bit index within the current phase
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;
  logic        sck_en_q, sck_en_d;
  logic        bs_q, bs_d;
  logic        end_q, end_d;
  logic        abort;

  // A load in flight dies if the programmer gives up or drops read early.
  // END is excluded so the completion handshake always finishes.
  always_comb begin
    abort = 1'b0;
    if (state_q inside {S_ARMED, S_CMD, S_ADDR, S_DUMMY, S_STREAM} &&
        !prog_chan_in_progress)
      abort = 1'b1;
    if (state_q inside {S_CMD, S_ADDR, S_DUMMY, S_STREAM} && !read_bitstream)
      abort = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    cs_n_d   = cs_n_q;
    mosi_d   = mosi_q;
    sck_en_d = sck_en_q;
    bs_d     = bs_q;
    end_d    = end_q;

    unique case (state_q)
      S_IDLE: begin
        if (store_flash_command) begin
          sreg_d  = {READ_CMD, START_ADDR};
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (read_bitstream) begin
          // The first command bit is launched together with CS so that it
          // is valid for the first SCK rising edge.
          state_d  = S_CMD;
          cs_n_d   = 1'b0;
          sck_en_d = 1'b1;
          mosi_d   = sreg_q[31];
          sreg_d   = {sreg_q[30:0], 1'b0};
          cnt_d    = '0;
        end
      end
      S_CMD: begin
        mosi_d = sreg_q[31];
        sreg_d = {sreg_q[30:0], 1'b0};
        if (cnt_q == 32'd7) begin
          state_d = S_ADDR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_ADDR: begin
        if (cnt_q == 32'd23) begin
          mosi_d = 1'b0;
          cnt_d  = '0;
`ifdef CHAN_FAST_READ_EN
          state_d = S_DUMMY;
`else
          state_d = S_STREAM;
`endif
        end else begin
          mosi_d = sreg_q[31];
          sreg_d = {sreg_q[30:0], 1'b0};
          cnt_d  = cnt_q + 32'd1;
        end
      end
      S_DUMMY: begin
        mosi_d = 1'b0;
        if (cnt_q == 32'd7) begin
          state_d = S_STREAM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_STREAM: begin
        bs_d = spi_miso;
        // The last bit and the completion flag go out together, and the
        // flash is released in that same cycle.
        if (cnt_q == NUM_BITS - 32'd1) begin
          state_d  = S_END;
          cs_n_d   = 1'b1;
          sck_en_d = 1'b0;
          end_d    = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_END: begin
        bs_d = 1'b1;
        if (!read_bitstream) begin
          state_d = S_IDLE;
          end_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d  = S_IDLE;
      cs_n_d   = 1'b1;
      sck_en_d = 1'b0;
      mosi_d   = 1'b0;
      bs_d     = 1'b1;
      end_d    = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      sreg_q   <= '0;
      cnt_q    <= '0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
      sck_en_q <= 1'b0;
      bs_q     <= 1'b1;
      end_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      cs_n_q   <= cs_n_d;
      mosi_q   <= mosi_d;
      sck_en_q <= sck_en_d;
      bs_q     <= bs_d;
      end_q    <= end_d;
    end
  end

  assign spi_cs_n      = cs_n_q;
  assign spi_mosi      = mosi_q;
  assign spi_sck_en    = sck_en_q;
  assign bitstream     = bs_q;
  assign end_bitstream = end_q;

endmodule

// File: tb/tb_chan_bitstream_reader.sv
// Bench for chan_bitstream_reader: SPI flash model plus a timeline model of
// what each output must show in every cycle of a load.
module tb_chan_bitstream_reader;
  localparam logic [23:0] SA = 24'hCE0000;
  localparam int          N  = 16;
`ifdef CHAN_FAST_READ_EN
  localparam int          HDR  = 40;
  localparam logic [7:0]  CMDB = 8'h0B;
  localparam logic [31:0] HDR_LIT = 32'h0BCE0000;
  localparam int          END_LIT = 56;
`else
  localparam int          HDR  = 32;
  localparam logic [7:0]  CMDB = 8'h03;
  localparam logic [31:0] HDR_LIT = 32'h03CE0000;
  localparam int          END_LIT = 48;
`endif

  logic clk = 1'b0;
  logic reset_n, prog, store, read, spi_miso;
  logic spi_cs_n, spi_mosi, spi_sck_en, bitstream, end_bitstream;
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  chan_bitstream_reader #(.START_ADDR(SA), .NUM_BITS(32'(N))) dut (
    .clk(clk), .reset_n(reset_n), .prog_chan_in_progress(prog),
    .store_flash_command(store), .read_bitstream(read), .spi_miso(spi_miso),
    .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_sck_en(spi_sck_en),
    .bitstream(bitstream), .end_bitstream(end_bitstream)
  );

  // Flash contents around the bitstream; other addresses read as C3 so a
  // wrong address shows up as wrong data.
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    if (a == SA)          return 8'hA5;
    if (a == SA + 24'd1)  return 8'h5A;
    return 8'hC3;
  endfunction

  // ---- flash model: shifts in the header on SCK rise, then drives data ----
  logic [39:0] rx = '0;
  int          nbits = 0;
  always @(negedge clk) begin
    if (spi_cs_n) nbits <= 0;
    else if (spi_sck_en && nbits < HDR) begin
      rx    <= {rx[38:0], spi_mosi};
      nbits <= nbits + 1;
    end else if (spi_sck_en) nbits <= nbits + 1;
  end
  always @(posedge clk) begin
    logic [23:0] a;
    logic [7:0]  b;
    int          idx;
    #1;
    if (!spi_cs_n && nbits >= HDR) begin
`ifdef CHAN_FAST_READ_EN
      a = rx[31:8];
`else
      a = rx[23:0];
`endif
      idx = nbits - HDR;
      b = fbyte(a + 24'(idx / 8));
      spi_miso = b[7 - (idx % 8)];
    end else spi_miso = 1'b0;
  end

  // ---- reference timeline (cycle 0 = first cycle with CS low) ----
  function automatic logic m_cs(input int c);
    return !(c >= 0 && c <= HDR + N - 1);
  endfunction
  function automatic logic m_mosi(input int c);
    logic [31:0] h;
    h = {CMDB, SA};
    if (c >= 0 && c < 32) return h[31 - c];
    return 1'b0;
  endfunction
  function automatic logic m_bs(input int c);
    logic [7:0] b;
    int k;
    if (c >= HDR + 1 && c <= HDR + N) begin
      k = c - HDR - 1;
      b = fbyte(SA + 24'(k / 8));
      return b[7 - (k % 8)];
    end
    return 1'b1;
  endfunction
  function automatic logic m_end(input int c);
    return c >= HDR + N;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
    else n_pass++;
  endtask
  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic cmp_cycle(input int c);
    chk($sformatf("cs_n c%0d", c), spi_cs_n, m_cs(c));
    chk($sformatf("sck_en c%0d", c), spi_sck_en, !m_cs(c));
    chk($sformatf("mosi c%0d", c), spi_mosi, m_mosi(c));
    chk($sformatf("bitstream c%0d", c), bitstream, m_bs(c));
    chk($sformatf("end c%0d", c), end_bitstream, m_end(c));
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, " cs_n"}, spi_cs_n, 1'b1);
    chk({tag, " sck_en"}, spi_sck_en, 1'b0);
    chk({tag, " bitstream"}, bitstream, 1'b1);
    chk({tag, " end"}, end_bitstream, 1'b0);
  endtask

  // mode 0: full load + handshake; 1: abort at cycle 20; 2: reset at cycle 40
  task automatic run_txn(input int mode);
    logic [31:0]  hdr_got;
    logic [N-1:0] bits_got;
    int end_at, cs_at;
    hdr_got = '0; bits_got = '0; end_at = -1; cs_at = -1;
    @(negedge clk); store = 1'b1;
    @(negedge clk); store = 1'b0; read = 1'b1;
    idle_chk("armed");
    for (int c = 0; c <= HDR + N + 5; c++) begin
      @(negedge clk);
      cmp_cycle(c);
      if (c < 32) hdr_got[31 - c] = spi_mosi;
      if (c >= HDR + 1 && c <= HDR + N) bits_got[N - 1 - (c - HDR - 1)] = bitstream;
      if (end_bitstream && end_at < 0) end_at = c;
      if (spi_cs_n && cs_at < 0) cs_at = c;
      if (mode == 1 && c == 20) begin prog = 1'b0; break; end
      if (mode == 2 && c == 40) begin reset_n = 1'b0; #1; idle_chk("async rst"); break; end
    end
    if (mode == 0) begin
      chk32("mosi header", hdr_got, HDR_LIT);
      chk32("data bits", 32'(bits_got), 32'(16'b1010010101011010));
      chk32("end cycle", 32'(end_at), 32'(END_LIT));
      chk32("cs rise cycle", 32'(cs_at), 32'(END_LIT));
      read = 1'b0;
      @(negedge clk); idle_chk("release");
      @(negedge clk); idle_chk("release+1");
    end else if (mode == 1) begin
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk); idle_chk($sformatf("abort+%0d", k));
      end
      prog = 1'b1; read = 1'b0;
      @(negedge clk); read = 1'b1;  // read alone must not restart from IDLE
      for (int k = 0; k < 4; k++) begin
        @(negedge clk); idle_chk($sformatf("post-abort read %0d", k));
      end
      read = 1'b0;
    end else begin
      repeat (2) @(negedge clk);
      idle_chk("in rst");
      read = 1'b0; reset_n = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n = 1'b0; prog = 1'b0; store = 1'b0; read = 1'b0; spi_miso = 1'b0;
    repeat (2) @(negedge clk);
    idle_chk("reset");
    chk("reset mosi", spi_mosi, 1'b0);
    reset_n = 1'b1; prog = 1'b1;
    // read without a prior store is ignored
    @(negedge clk); read = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); idle_chk($sformatf("no-store %0d", k));
    end
    read = 1'b0;
    @(negedge clk);
    run_txn(0);
    run_txn(0);
    run_txn(1);
    run_txn(2);
    run_txn(0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
